// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: op codes,
// FSM encoding, special-case constants and a magnitude helper.
package muldiv_pkg;

    localparam int MD_XLEN  = 32;
    localparam int MD_CNT_W = 5;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MUL     = 2'd1,
        S_DIV_RUN = 2'd2,
        S_DONE    = 2'd3
    } md_state_e;

    localparam logic [MD_XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [MD_XLEN-1:0] INT_MIN    = 32'h8000_0000;

    function automatic logic [MD_XLEN-1:0] md_abs(input logic [MD_XLEN-1:0] v,
                                                  input logic             is_signed);
        if (is_signed && v[MD_XLEN-1]) begin
            md_abs = ~v + 32'd1;
        end else begin
            md_abs = v;
        end
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the EX stage and the muldiv sequencer.
interface muldiv_sequencer_if
    import muldiv_pkg::*;
    #(parameter int XLEN = MD_XLEN);

    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, operand_a, operand_b, flush,
        input  stall, busy, result_valid, result
    );

    modport slave (
        input  start, funct3, operand_a, operand_b, flush,
        output stall, busy, result_valid, result
    );

endinterface

// File: rtl/muldiv_sequencer_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits and record the quotient bit.
module div_restoring_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] q,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] q_next
);

    // The extra top bit keeps the bit shifted out of rem, so divisors at or
    // above 2^(XLEN-1) still compare correctly.
    logic [XLEN:0] shifted_s;
    assign shifted_s = {rem, q[XLEN-1]};

    // Compare-and-subtract for this step
    always_comb begin
        if (shifted_s >= {1'b0, divisor}) begin
            rem_next = shifted_s[XLEN-1:0] - divisor;
            q_next   = {q[XLEN-2:0], 1'b1};
        end else begin
            rem_next = shifted_s[XLEN-1:0];
            q_next   = {q[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M execution controller: registered multiply, 32-step restoring divide,
// immediate resolution of divide-by-zero and signed overflow.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN  = MD_XLEN,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic              CLK,
    input  logic              RESET,
    muldiv_sequencer_if.slave md
);

    md_state_e       state_r, state_n;
    logic [2:0]      op_r, op_n;
    logic [XLEN-1:0] a_r, a_n, b_r, b_n;
    logic [XLEN-1:0] rem_r, rem_n, q_r, q_n, div_r, div_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic            neg_q_r, neg_q_n, neg_rem_r, neg_rem_n;
    logic [XLEN-1:0] result_r, result_n;

    logic [XLEN-1:0] step_rem_s, step_q_s;
    logic            a_sgn_s, b_sgn_s, div_sgn_s;
    logic signed [2*XLEN+1:0] a_ext_s, b_ext_s, prod_s;

    div_restoring_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_r),
        .q        (q_r),
        .divisor  (div_r),
        .rem_next (step_rem_s),
        .q_next   (step_q_s)
    );

    // Sign-extend per op so a single signed multiply covers all four variants
    assign a_sgn_s = (op_r == MD_MULH) || (op_r == MD_MULHSU);
    assign b_sgn_s = (op_r == MD_MULH);
    assign a_ext_s = {{(XLEN+2){a_r[XLEN-1] & a_sgn_s}}, a_r};
    assign b_ext_s = {{(XLEN+2){b_r[XLEN-1] & b_sgn_s}}, b_r};
    assign prod_s  = a_ext_s * b_ext_s;

    assign div_sgn_s = ~md.funct3[0];

    // Next-state and datapath update
    always_comb begin
        state_n   = state_r;
        op_n      = op_r;
        a_n       = a_r;
        b_n       = b_r;
        rem_n     = rem_r;
        q_n       = q_r;
        div_n     = div_r;
        cnt_n     = cnt_r;
        neg_q_n   = neg_q_r;
        neg_rem_n = neg_rem_r;
        result_n  = result_r;
        case (state_r)
            S_IDLE: begin
                if (md.flush) begin
                    state_n = S_IDLE;
                end else if (md.start) begin
                    op_n = md.funct3;
                    a_n  = md.operand_a;
                    b_n  = md.operand_b;
                    if (!md.funct3[2]) begin
                        state_n = S_MUL;
                    end else if (md.operand_b == 32'd0) begin
                        result_n = md.funct3[1] ? md.operand_a : DIV_ZERO_Q;
                        state_n  = S_DONE;
                    end else if (div_sgn_s && (md.operand_a == INT_MIN)
                                 && (md.operand_b == 32'hFFFF_FFFF)) begin
                        result_n = md.funct3[1] ? 32'd0 : INT_MIN;
                        state_n  = S_DONE;
                    end else begin
                        q_n       = md_abs(md.operand_a, div_sgn_s);
                        div_n     = md_abs(md.operand_b, div_sgn_s);
                        rem_n     = 32'd0;
                        cnt_n     = '0;
                        neg_q_n   = div_sgn_s & (md.operand_a[XLEN-1] ^ md.operand_b[XLEN-1]);
                        neg_rem_n = div_sgn_s & md.operand_a[XLEN-1];
                        state_n   = S_DIV_RUN;
                    end
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_MUL: begin
                if (md.flush) begin
                    state_n = S_IDLE;
                end else begin
                    result_n = (op_r == MD_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
                    state_n  = S_DONE;
                end
            end
            S_DIV_RUN: begin
                if (md.flush) begin
                    state_n = S_IDLE;
                end else begin
                    rem_n = step_rem_s;
                    q_n   = step_q_s;
                    cnt_n = cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(XLEN-1)) begin
                        // Signs were stripped on entry; restore them on the last step
                        if (op_r[1]) begin
                            result_n = neg_rem_r ? (~step_rem_s + 32'd1) : step_rem_s;
                        end else begin
                            result_n = neg_q_r ? (~step_q_s + 32'd1) : step_q_s;
                        end
                        state_n = S_DONE;
                    end else begin
                        state_n = S_DIV_RUN;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r   <= S_IDLE;
            op_r      <= 3'd0;
            a_r       <= 32'd0;
            b_r       <= 32'd0;
            rem_r     <= 32'd0;
            q_r       <= 32'd0;
            div_r     <= 32'd0;
            cnt_r     <= '0;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            result_r  <= 32'd0;
        end else begin
            state_r   <= state_n;
            op_r      <= op_n;
            a_r       <= a_n;
            b_r       <= b_n;
            rem_r     <= rem_n;
            q_r       <= q_n;
            div_r     <= div_n;
            cnt_r     <= cnt_n;
            neg_q_r   <= neg_q_n;
            neg_rem_r <= neg_rem_n;
            result_r  <= result_n;
        end
    end

    assign md.stall = ~RESET & (((state_r == S_IDLE) & md.start)
                               | (state_r == S_MUL) | (state_r == S_DIV_RUN));
    assign md.busy         = (state_r != S_IDLE);
    assign md.result_valid = (state_r == S_DONE);
    assign md.result       = result_r;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle execution controller for the RV32M instructions (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the EX-stage ALU.
- It accepts one operation from ID/EX and stalls the pipeline while it works. It runs a registered multiply or a 32-step restoring divide, then presents the result for exactly one cycle.
- It resolves RISC-V divide-by-zero and signed-overflow cases without iterating.

Parameters:
- XLEN, 32, operand/result width; the divide iteration count equals XLEN.
- CNT_W, 5, width of the iteration counter; equals clog2(XLEN).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- start  in  1  high while an M-extension instruction occupies EX; held stable by the stall.
- funct3  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a  in  XLEN  rs1 value (dividend / multiplicand).
- operand_b  in  XLEN  rs2 value (divisor / multiplier).
- flush  in  1  kill the in-flight op (branch/jump redirect).
- stall  out  1  freeze PC, IF/ID and ID/EX; combinational.
- busy  out  1  high in any state other than IDLE.
- result_valid  out  1  one-cycle pulse; result is meaningful only in this cycle.
- result  out  XLEN  final value for EX/MEM.

Behaviour:
- States: IDLE, MUL, DIV_RUN, DONE.
- Reset (has priority over flush): state=IDLE, counter=0, all internal registers=0.
- Outputs while in reset: result=0, result_valid=0, busy=0, stall=0.
- stall = (IDLE & start) | MUL | DIV_RUN. stall is low in DONE, so the pipeline advances on the DONE edge.
- IDLE with start: latch funct3 and both operands, then branch by operation.
  - funct3[2]=0 -> MUL.
  - Divide with operand_b=0 -> DONE. DIV/DIVU result=0xFFFFFFFF; REM/REMU result=operand_a.
  - DIV/REM with a=0x80000000, b=0xFFFFFFFF -> DONE. DIV result=0x80000000; REM result=0.
  - Any other divide -> DIV_RUN. Latch |a| and |b| for signed ops (raw values for unsigned ops), clear the remainder, counter=0.
- MUL: form the 64-bit product with signedness per op (MULHSU: a signed, b unsigned).
  - Register the low word for MUL, the high word otherwise.
  - -> DONE.
- DIV_RUN, one restoring step per cycle:
  - rem = {rem[XLEN-2:0], q[XLEN-1]}, q <<= 1.
  - If rem >= divisor: rem -= divisor and q[0]=1.
  - counter++. After the step with counter=XLEN-1, -> DONE.
- Final sign fix-up before DONE: quotient negated if signs differ (DIV); remainder takes the dividend's sign (REM).
- DONE: result_valid=1, result holds the value, start ignored (it still shows the finished instruction). -> IDLE next cycle.
- Latency from the start edge to the result_valid cycle: mul 2 cycles; special-case divide 1 cycle; normal divide 33 cycles.
- result holds its last value outside DONE.
- flush in any state -> IDLE next edge; result_valid stays 0 and no result is produced.
  - A flush coinciding with DONE suppresses nothing, because the pulse is already out.
  - flush & start in IDLE: flush wins, and the op is not accepted.
- Back-to-back ops: the next start is accepted in the IDLE cycle after DONE.

Decomposition:
- Shared package muldiv_pkg holds:
  - funct3 codes (MD_MUL … MD_REMU)
  - the state encoding
  - the constants DIV_ZERO_Q=all-ones and INT_MIN=0x80000000
- One natural sub-module: div_restoring_step, combinational. Inputs rem, q, divisor; outputs next rem and next q. Instantiated once and iterated.

Test Plan:
- MUL 7×(-3) (a=7, b=0xFFFFFFFD) -> stall high 2 cycles; result_valid at cycle 2; result=0xFFFFFFEB.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> result=0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 -> result=0xFFFFFFFF.
- DIV -7/2 (a=0xFFFFFFF9, b=2) -> valid at cycle 33; result=0xFFFFFFFD. REM on the same operands -> result=0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM on the same overflow case -> 0. Each with valid at cycle 1 and no DIV_RUN cycles.
- Start DIV, assert flush at cycle 10 -> IDLE at cycle 11, stall low, no result_valid pulse. A following MUL 3×4 -> result 12.
- RESET asserted during DIV_RUN at cycle 5, with flush high simultaneously -> next edge IDLE. Then busy=0, stall=0, result=0, result_valid=0.
